// File: rtl/a2_mailbox_pkg.sv
// Shared constants for the PicoSoC <-> Apple II mailbox: iomem register map,
// STATUS/CONTROL bit positions and the A2-side status byte layout.
package a2_mailbox_pkg;

  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_TXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int STAT_A2S_COUNT_LSB = 0;
  localparam int STAT_S2A_COUNT_LSB = 8;
  localparam int STAT_A2S_OVF       = 16;
  localparam int STAT_S2A_OVF       = 17;
  localparam int STAT_A2S_UNF       = 18;
  localparam int STAT_S2A_UNF       = 19;

  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_FLUSH_A2S = 1;
  localparam int CTRL_FLUSH_S2A = 2;
  localparam int CTRL_CLR_FLAGS = 3;

  localparam int A2_STAT_A2S_FULL     = 6;
  localparam int A2_STAT_S2A_NONEMPTY = 7;

endpackage

// File: rtl/a2_mailbox_fifo.sv
// Byte FIFO, first-word-fall-through, with occupancy count, flush and
// single-cycle overflow/underflow pulses. A pop frees room for a same-cycle push.
module a2_mailbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign head      = empty ? 8'h00 : mem_q[rd_ptr_q];
  // Flush wins over everything, including the error pulses.
  assign pop_ok_s  = pop & ~empty & ~flush;
  assign push_ok_s = push & (~full | pop_ok_s) & ~flush;
  assign overflow  = push & full & ~pop_ok_s & ~flush;
  assign underflow = pop & empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/picosoc_a2_mailbox.sv
// Multi-channel byte mailbox between a PicoSoC iomem slave and an Apple II bus
// window; one a2s and one s2a FIFO per channel plus sticky error flags and irq.
module picosoc_a2_mailbox
  import a2_mailbox_pkg::*;
#(
  parameter int          NUM_CHANNELS = 2,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] A2_BASE_ADDR = 16'hC0C0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  input  logic [15:0] a2_addr,
  input  logic        a2_rw_n,
  input  logic [7:0]  a2_data_in,
  input  logic        a2_data_in_strobe,
  output logic [7:0]  a2_data_out,
  output logic        a2_rd_en,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [16:0] a2_off_s;
  logic        a2_hit_s, a2_stat_s;
  logic [2:0]  a2_ch_s, io_ch_s;
  logic [1:0]  io_reg_s;
  logic        io_wr_s, io_go_s;
  logic        unused_s;

  logic [NUM_CHANNELS-1:0] a2s_push_s, a2s_pop_s, a2s_flush_s, a2s_full_s, a2s_empty_s;
  logic [NUM_CHANNELS-1:0] s2a_push_s, s2a_pop_s, s2a_flush_s, s2a_full_s, s2a_empty_s;
  logic [NUM_CHANNELS-1:0] a2s_ovf_s, a2s_unf_s, s2a_ovf_s, s2a_unf_s, ctrl_wr_s, clr_s;
  logic [7:0]              a2s_head_s [NUM_CHANNELS];
  logic [7:0]              s2a_head_s [NUM_CHANNELS];
  logic [CW-1:0]           a2s_cnt_s  [NUM_CHANNELS];
  logic [CW-1:0]           s2a_cnt_s  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] irq_en_q, irq_en_d;
  logic [NUM_CHANNELS-1:0] a2s_ovf_q, a2s_ovf_d, s2a_ovf_q, s2a_ovf_d;
  logic [NUM_CHANNELS-1:0] a2s_unf_q, a2s_unf_d, s2a_unf_q, s2a_unf_d;
  logic                    valid_q, valid_d, ready_q, ready_d, irq_q, irq_d;
  logic [31:0]             rdata_q, rdata_d;

  // The subtraction is done one bit wider so addresses below the base fall out.
  assign a2_off_s  = {1'b0, a2_addr} - {1'b0, A2_BASE_ADDR};
  assign a2_hit_s  = ~a2_off_s[16] & (a2_off_s[15:0] < 16'(2 * NUM_CHANNELS));
  assign a2_ch_s   = a2_off_s[3:1];
  assign a2_stat_s = a2_off_s[0];
  assign a2_rd_en  = a2_rw_n & a2_hit_s;

  assign io_ch_s  = iomem_addr[6:4];
  assign io_reg_s = iomem_addr[3:2];
  assign io_wr_s  = |iomem_wstrb;
  assign io_go_s  = iomem_valid & ~valid_q;
  assign valid_d  = iomem_valid;
  assign unused_s = ^{iomem_addr[31:7], iomem_addr[1:0], iomem_wdata[31:8], s2a_full_s};

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic io_sel_s, a2_sel_s;
    assign io_sel_s       = io_go_s & (io_ch_s == 3'(c));
    assign a2_sel_s       = a2_data_in_strobe & a2_hit_s & ~a2_stat_s & (a2_ch_s == 3'(c));
    assign a2s_push_s[c]  = a2_sel_s & ~a2_rw_n;
    assign s2a_pop_s[c]   = a2_sel_s & a2_rw_n;
    assign a2s_pop_s[c]   = io_sel_s & ~io_wr_s & (io_reg_s == REG_RXDATA);
    assign s2a_push_s[c]  = io_sel_s & io_wr_s & (io_reg_s == REG_TXDATA);
    assign ctrl_wr_s[c]   = io_sel_s & io_wr_s & (io_reg_s == REG_CONTROL);
    assign a2s_flush_s[c] = ctrl_wr_s[c] & iomem_wdata[CTRL_FLUSH_A2S];
    assign s2a_flush_s[c] = ctrl_wr_s[c] & iomem_wdata[CTRL_FLUSH_S2A];
    assign clr_s[c]       = ctrl_wr_s[c] & iomem_wdata[CTRL_CLR_FLAGS];

    a2_mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_a2s (
      .clk(clk), .reset(reset), .push(a2s_push_s[c]), .push_data(a2_data_in),
      .pop(a2s_pop_s[c]), .flush(a2s_flush_s[c]), .head(a2s_head_s[c]),
      .count(a2s_cnt_s[c]), .full(a2s_full_s[c]), .empty(a2s_empty_s[c]),
      .overflow(a2s_ovf_s[c]), .underflow(a2s_unf_s[c])
    );

    a2_mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_s2a (
      .clk(clk), .reset(reset), .push(s2a_push_s[c]), .push_data(iomem_wdata[7:0]),
      .pop(s2a_pop_s[c]), .flush(s2a_flush_s[c]), .head(s2a_head_s[c]),
      .count(s2a_cnt_s[c]), .full(s2a_full_s[c]), .empty(s2a_empty_s[c]),
      .overflow(s2a_ovf_s[c]), .underflow(s2a_unf_s[c])
    );
  end

  // A same-cycle error re-sets the flag even if CONTROL clears it.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      irq_en_d[c] = ctrl_wr_s[c] ? iomem_wdata[CTRL_IRQ_EN] : irq_en_q[c];
    end
    a2s_ovf_d = (a2s_ovf_q & ~clr_s) | a2s_ovf_s;
    s2a_ovf_d = (s2a_ovf_q & ~clr_s) | s2a_ovf_s;
    a2s_unf_d = (a2s_unf_q & ~clr_s) | a2s_unf_s;
    s2a_unf_d = (s2a_unf_q & ~clr_s) | s2a_unf_s;
    irq_d     = |(irq_en_q & ~a2s_empty_s);
    ready_d   = io_go_s;
  end

  always_comb begin
    rdata_d = 32'h0000_0000;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (io_go_s && !io_wr_s && (io_ch_s == 3'(c))) begin
        case (io_reg_s)
          REG_RXDATA:  rdata_d = {24'h00_0000, a2s_head_s[c]};
          REG_STATUS: begin
            rdata_d[STAT_A2S_COUNT_LSB +: 8] = 8'(a2s_cnt_s[c]);
            rdata_d[STAT_S2A_COUNT_LSB +: 8] = 8'(s2a_cnt_s[c]);
            rdata_d[STAT_A2S_OVF]            = a2s_ovf_q[c];
            rdata_d[STAT_S2A_OVF]            = s2a_ovf_q[c];
            rdata_d[STAT_A2S_UNF]            = a2s_unf_q[c];
            rdata_d[STAT_S2A_UNF]            = s2a_unf_q[c];
          end
          REG_CONTROL: rdata_d = {31'h0000_0000, irq_en_q[c]};
          default:     rdata_d = 32'h0000_0000;
        endcase
      end
    end
  end

  always_comb begin
    a2_data_out = 8'h00;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (a2_hit_s && (a2_ch_s == 3'(c))) begin
        if (a2_stat_s) begin
          a2_data_out[A2_STAT_S2A_NONEMPTY] = ~s2a_empty_s[c];
          a2_data_out[A2_STAT_A2S_FULL]     = a2s_full_s[c];
        end else begin
          a2_data_out = s2a_head_s[c];
        end
      end
    end
  end

  // valid_q restarts from the live valid so an access straddling reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= iomem_valid;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      irq_q     <= 1'b0;
      irq_en_q  <= '0;
      a2s_ovf_q <= '0;
      s2a_ovf_q <= '0;
      a2s_unf_q <= '0;
      s2a_unf_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      irq_en_q  <= irq_en_d;
      a2s_ovf_q <= a2s_ovf_d;
      s2a_ovf_q <= s2a_ovf_d;
      a2s_unf_q <= a2s_unf_d;
      s2a_unf_q <= s2a_unf_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_picosoc_a2_mailbox.sv
// Scoreboard bench for picosoc_a2_mailbox: a queue-based mailbox model predicts
// every iomem read and A2 output; a monitor checks each iomem_ready pulse.
module tb_picosoc_a2_mailbox;

  localparam int          NCH   = 2;
  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'hC0C0;

  logic        clk, reset;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic        iomem_ready;
  logic [15:0] a2_addr;
  logic        a2_rw_n, a2_data_in_strobe, a2_rd_en, irq_o;
  logic [7:0]  a2_data_in, a2_data_out;

  picosoc_a2_mailbox #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .A2_BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready),
    .a2_addr(a2_addr), .a2_rw_n(a2_rw_n), .a2_data_in(a2_data_in),
    .a2_data_in_strobe(a2_data_in_strobe), .a2_data_out(a2_data_out),
    .a2_rd_en(a2_rd_en), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic is_rd; logic [31:0] val;} exp_t;
  exp_t exp_q[$];

  // Reference model: plain byte queues and flag bits per channel.
  logic [7:0]   a2s_m [NCH][$];
  logic [7:0]   s2a_m [NCH][$];
  bit [NCH-1:0] a2s_ovf_m, s2a_ovf_m, a2s_unf_m, s2a_unf_m, irq_en_m;

  int n_pass = 0, n_total = 0, n_issued = 0, n_ready = 0;
  logic       exp_hit, exp_rd_en;
  logic [7:0] exp_do;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic irq_model();
    logic r = 1'b0;
    for (int c = 0; c < NCH; c++) if (irq_en_m[c] && a2s_m[c].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      a2s_m[c].delete();
      s2a_m[c].delete();
    end
    a2s_ovf_m = '0; s2a_ovf_m = '0; a2s_unf_m = '0; s2a_unf_m = '0; irq_en_m = '0;
  endtask

  // Drives an iomem access and records the model's prediction for it.
  task automatic io_start(input int ch, input int rg, input bit wr, input logic [31:0] wd);
    logic [31:0] e;
    e           = 32'h0;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000 | (32'(ch) << 4) | (32'(rg) << 2);
    iomem_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
    iomem_wdata = wd;
    if (ch < NCH) begin
      case (rg)
        0: if (!wr) begin
             if (a2s_m[ch].size() == 0) a2s_unf_m[ch] = 1'b1;
             else e = {24'h0, a2s_m[ch].pop_front()};
           end
        1: if (wr) begin
             if (s2a_m[ch].size() == DEPTH) s2a_ovf_m[ch] = 1'b1;
             else s2a_m[ch].push_back(wd[7:0]);
           end
        2: e = {12'h0, s2a_unf_m[ch], a2s_unf_m[ch], s2a_ovf_m[ch], a2s_ovf_m[ch],
                8'(s2a_m[ch].size()), 8'(a2s_m[ch].size())};
        default: if (wr) begin
             irq_en_m[ch] = wd[0];
             if (wd[1]) a2s_m[ch].delete();
             if (wd[2]) s2a_m[ch].delete();
             if (wd[3]) begin
               a2s_ovf_m[ch] = 1'b0; s2a_ovf_m[ch] = 1'b0;
               a2s_unf_m[ch] = 1'b0; s2a_unf_m[ch] = 1'b0;
             end
           end else e = {31'h0, irq_en_m[ch]};
      endcase
    end
    exp_q.push_back({~wr, e});
    n_issued++;
  endtask

  task automatic a2_expect(input logic [15:0] addr, input bit rw_n, input logic [7:0] d);
    int ofs, ch;
    a2_addr = addr; a2_rw_n = rw_n; a2_data_in = d; a2_data_in_strobe = 1'b1;
    ofs       = int'(addr) - int'(BASE);
    exp_hit   = (ofs >= 0) && (ofs < 2 * NCH);
    exp_rd_en = rw_n && exp_hit;
    exp_do    = 8'h00;
    if (exp_hit) begin
      ch = ofs / 2;
      if (ofs % 2 == 1) exp_do = {s2a_m[ch].size() != 0, a2s_m[ch].size() == DEPTH, 6'b0};
      else if (s2a_m[ch].size() != 0) exp_do = s2a_m[ch][0];
    end
  endtask

  task automatic a2_apply(input logic [15:0] addr, input bit rw_n, input logic [7:0] d);
    int ofs, ch;
    ofs = int'(addr) - int'(BASE);
    if (ofs >= 0 && ofs < 2 * NCH && ofs % 2 == 0) begin
      ch = ofs / 2;
      if (!rw_n) begin
        if (a2s_m[ch].size() == DEPTH) a2s_ovf_m[ch] = 1'b1;
        else a2s_m[ch].push_back(d);
      end else begin
        if (s2a_m[ch].size() == 0) s2a_unf_m[ch] = 1'b1;
        else void'(s2a_m[ch].pop_front());
      end
    end
  endtask

  task automatic a2_compare();
    check("a2_rd_en", {31'h0, a2_rd_en}, {31'h0, exp_rd_en});
    if (exp_hit) check("a2_data_out", {24'h0, a2_data_out}, {24'h0, exp_do});
  endtask

  task automatic a2_idle();
    a2_data_in_strobe = 1'b0; a2_addr = 16'h0000; a2_rw_n = 1'b1;
  endtask

  task automatic check_irq();
    check("irq_o", {31'h0, irq_o}, {31'h0, irq_model()});
  endtask

  task automatic do_io(input int ch, input int rg, input bit wr, input logic [31:0] wd,
                       input int hold);
    @(negedge clk);
    io_start(ch, rg, wr, wd);
    repeat (hold) @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
    check_irq();
  endtask

  task automatic do_a2(input logic [15:0] addr, input bit rw_n, input logic [7:0] d);
    @(negedge clk);
    a2_expect(addr, rw_n, d);
    a2_apply(addr, rw_n, d);
    #1 a2_compare();
    @(negedge clk);
    a2_idle();
    @(negedge clk);
    check_irq();
  endtask

  // io_first selects which side the model applies first within the shared cycle.
  task automatic do_both(input int ch, input int rg, input bit wr, input logic [31:0] wd,
                         input logic [15:0] addr, input bit rw_n, input logic [7:0] d,
                         input bit io_first);
    @(negedge clk);
    a2_expect(addr, rw_n, d);
    if (io_first) begin
      io_start(ch, rg, wr, wd);
      a2_apply(addr, rw_n, d);
    end else begin
      a2_apply(addr, rw_n, d);
      io_start(ch, rg, wr, wd);
    end
    #1 a2_compare();
    @(negedge clk);
    iomem_valid = 1'b0;
    a2_idle();
    @(negedge clk);
    check_irq();
  endtask

  always @(negedge clk) begin
    if (iomem_ready === 1'b1) begin
      n_ready++;
      if (exp_q.size() == 0) begin
        check("ready_unexpected", {31'h0, iomem_ready}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_rd) check("iomem_rdata", iomem_rdata, e.val);
      end
    end
  end

  initial begin
    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 32'h0;
    iomem_wdata = 32'h0; a2_addr = 16'h0; a2_rw_n = 1'b1; a2_data_in = 8'h0;
    a2_data_in_strobe = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, iomem_ready}, 32'h0);
    check("reset_rdata", iomem_rdata, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    reset = 1'b0;

    // A2 -> SoC bytes come back in order; irq tracks a2s occupancy.
    do_io(0, 3, 1'b1, 32'h1, 1);
    do_a2(16'hC0C0, 1'b0, 8'h41);
    do_a2(16'hC0C0, 1'b0, 8'h42);
    do_a2(16'hC0C0, 1'b0, 8'h43);
    for (int i = 0; i < 3; i++) do_io(0, 0, 1'b0, 32'h0, 1 + i);
    do_io(0, 2, 1'b0, 32'h0, 1);

    // Overflow of ch1, then drain and underflow.
    for (int i = 0; i < 17; i++) do_a2(16'hC0C2, 1'b0, 8'(8'h60 + i));
    do_io(1, 2, 1'b0, 32'h0, 1);
    for (int i = 0; i < 17; i++) do_io(1, 0, 1'b0, 32'h0, 1);
    do_io(1, 2, 1'b0, 32'h0, 1);
    do_io(1, 3, 1'b1, 32'h8, 1);
    do_io(1, 2, 1'b0, 32'h0, 1);

    // SoC -> A2 byte, status bit and pop.
    do_io(0, 1, 1'b1, 32'h5A, 2);
    do_a2(16'hC0C1, 1'b1, 8'h00);
    do_a2(16'hC0C0, 1'b1, 8'h00);
    do_a2(16'hC0C1, 1'b1, 8'h00);
    do_a2(16'hC0C0, 1'b1, 8'h00);
    do_io(0, 2, 1'b0, 32'h0, 1);

    // Full FIFO push+pop, push+pop on empty, flush+push.
    do_io(0, 3, 1'b1, 32'h9, 1);
    for (int i = 0; i < 16; i++) do_a2(16'hC0C0, 1'b0, 8'($urandom));
    do_both(0, 0, 1'b0, 32'h0, 16'hC0C0, 1'b0, 8'h77, 1'b1);
    do_io(0, 2, 1'b0, 32'h0, 1);
    do_both(1, 0, 1'b0, 32'h0, 16'hC0C2, 1'b0, 8'h99, 1'b1);
    do_io(1, 2, 1'b0, 32'h0, 1);
    do_io(0, 0, 1'b0, 32'h0, 1);
    do_both(0, 3, 1'b1, 32'h3, 16'hC0C0, 1'b0, 8'h55, 1'b0);
    do_io(0, 2, 1'b0, 32'h0, 1);

    // Randomized traffic on both sides.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        logic [15:0] ad;
        ad = ($urandom_range(0, 15) == 0) ? BASE - 16'd1 : BASE + 16'($urandom_range(0, 2 * NCH));
        do_a2(ad, ($urandom_range(0, 9) < 3), 8'($urandom));
      end else begin
        int rg;
        logic [31:0] wd;
        rg = $urandom_range(0, 3);
        wd = $urandom;
        if (rg == 3) begin
          wd[1] = ($urandom_range(0, 7) == 0);
          wd[2] = ($urandom_range(0, 7) == 0);
          wd[3] = ($urandom_range(0, 3) == 0);
        end
        do_io($urandom_range(0, 3), rg, 1'($urandom_range(0, 1)), wd, $urandom_range(1, 3));
      end
    end

    // Reset while an access is pending: no ready, everything empty afterwards.
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0008; iomem_wstrb = 4'h0; reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("midreset_ready", {31'h0, iomem_ready}, 32'h0);
      check("midreset_rdata", iomem_rdata, 32'h0);
      check("midreset_irq", {31'h0, irq_o}, 32'h0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
    do_io(0, 2, 1'b0, 32'h0, 1);
    do_io(1, 2, 1'b0, 32'h0, 1);
    do_io(0, 3, 1'b0, 32'h0, 1);

    repeat (3) @(negedge clk);
    check("ready_count", n_ready, n_issued);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/picosoc_a2_mailbox.md
PICOSOC_A2_MAILBOX -- requirements
Module: picosoc_a2_mailbox

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_CHANNELS SHALL default to 2 (range 1..8) and set the number of independent mailbox channels.
REQ-003 Parameter FIFO_DEPTH SHALL default to 16 (power of two, 4..128) and set the entries per FIFO, per direction, per channel.
REQ-004 Parameter A2_BASE_ADDR SHALL default to 16'hC0C0 and set the first A2 bus address of the window.
REQ-005 Port clk SHALL be an input, 1 bit: the system clock.
REQ-006 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-007 Ports iomem_valid (in, 1), iomem_wstrb (in, 4), iomem_addr (in, 32), iomem_wdata (in, 32), iomem_rdata (out, 32) and iomem_ready (out, 1) SHALL form the PicoSoC iomem slave.
REQ-008 Ports a2_addr (in, 16), a2_rw_n (in, 1), a2_data_in (in, 8) and a2_data_in_strobe (in, 1) SHALL carry the Apple II bus cycle; the strobe is a single-cycle pulse per bus cycle.
REQ-009 Ports a2_data_out (out, 8) and a2_rd_en (out, 1) SHALL drive the A2 read data and its output enable.
REQ-010 Port irq_o (out, 1) SHALL be the PicoSoC interrupt request.

Function
REQ-011 Each channel SHALL own two FIFOs of FIFO_DEPTH bytes: a2s (A2 to SoC) and s2a (SoC to A2), both first-word-fall-through.
REQ-012 The A2 window SHALL use two addresses per channel: data at A2_BASE_ADDR+2*ch and status at A2_BASE_ADDR+2*ch+1.
REQ-013 An A2 write (a2_rw_n=0, strobe=1) to the data address SHALL push a2_data_in into a2s[ch]; writes to the status address SHALL be ignored.
REQ-014 a2_rd_en SHALL be combinational: 1 when a2_rw_n=1 and a2_addr is inside the window, else 0.
REQ-015 a2_data_out SHALL be the s2a[ch] head at the data address (8'h00 if empty), and {s2a_nonempty, a2s_full, 6'b0} at the status address.
REQ-016 An A2 read strobe at the data address SHALL pop s2a[ch] once; a pop on an empty FIFO SHALL set s2a_underflow and leave it empty.
REQ-017 iomem decoding SHALL use iomem_addr[6:4] as the channel and iomem_addr[3:2] as the register: 0 RXDATA, 1 TXDATA, 2 STATUS, 3 CONTROL; a channel index >= NUM_CHANNELS SHALL read 0 and ignore writes.
REQ-018 iomem_ready SHALL pulse for exactly one cycle, one cycle after iomem_valid rises; each access SHALL take effect exactly once even while valid is held.
REQ-019 A RXDATA read SHALL return {24'b0, a2s head} and pop a2s[ch]; if a2s is empty it SHALL return 0 and set a2s_underflow.
REQ-020 A TXDATA write (any wstrb bit) SHALL push iomem_wdata[7:0] into s2a[ch].
REQ-021 STATUS SHALL read [7:0] a2s count, [15:8] s2a count, [16] a2s_overflow, [17] s2a_overflow, [18] a2s_underflow, [19] s2a_underflow, others 0.
REQ-022 A CONTROL write SHALL set: bit0 irq_en (held); bit1 flush a2s, bit2 flush s2a, bit3 clear all four sticky flags (bits 1-3 act once, not stored); a CONTROL read SHALL return {31'b0, irq_en}.
REQ-023 A push to a full FIFO SHALL be dropped and set that FIFO's overflow flag, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL accept the push, return 0 for the pop and set underflow.
REQ-025 A flush SHALL take priority over a push or pop in the same cycle; the FIFO SHALL be empty the next cycle.
REQ-026 Sticky flags SHALL stay set until cleared by CONTROL bit3; a clear in the same cycle as a new error SHALL leave the flag set.
REQ-027 irq_o SHALL be registered: OR over all channels of (irq_en AND a2s nonempty), with one cycle of latency.

Reset
REQ-028 On reset, the block SHALL empty all FIFOs, clear all flags and irq_en, and drive iomem_ready=0, iomem_rdata=0 and irq_o=0; reset mid-transfer SHALL abort the access with no ready pulse.

Structure
REQ-029 Package a2_mailbox_pkg SHALL hold the register offset constants, the STATUS and CONTROL bit positions, and the A2 status bit positions.
REQ-030 One sub-module, a2_mailbox_fifo (FIFO with count, full/empty, flush, and overflow/underflow pulses), SHALL be instantiated twice per channel using a generate loop.

Verification
REQ-031 Three A2 writes of 8'h41, 8'h42, 8'h43 to C0C0, then three RXDATA reads of ch0 -> returns 41, 42, 43; STATUS[7:0]=0; irq_o falls after the last pop when irq_en=1.
REQ-032 17 A2 writes to C0C2 with FIFO_DEPTH=16 -> ch1 STATUS[7:0]=16 and bit16=1; the 17th byte is never read back.
REQ-033 TXDATA write of 8'h5A to ch0 -> a2_data_out=8'h5A and C0C1 status bit7=1; A2 read strobe at C0C0 -> status bit7=0 and s2a count=0.
REQ-034 RXDATA read of an empty FIFO -> rdata=0 and STATUS bit18=1; CONTROL write of 8 -> bit18=0.
REQ-035 Full FIFO with simultaneous A2 push and SoC pop -> count stays 16 and no overflow; flush plus push in the same cycle -> count=0.
REQ-036 Reset asserted while iomem_valid=1 -> no iomem_ready pulse; all counts read 0 after reset.
